// File: rtl/light_manager_multi.sv
// light_manager_multi: rotary-encoder brightness controller for N PWM LED channels.
// Encoder A/B and select button are synchronised, debounced, and decoded into
// UP/DOWN detent events that step the selected channel's duty with saturation.
// Optional macro LM_FADE_EN: PWM duty follows the stored duty by one step per
// PWM period instead of tracking it immediately.
module light_manager_multi #(
  parameter int unsigned CLOCK_FREQ_MHZ = 100,
  parameter int unsigned DELAY_IN_US    = 50,
  parameter int unsigned PWM_VALUE_SIZE = 8,
  parameter int unsigned BRIGHTNESS_INC = 5,
  parameter int unsigned N_CHANNELS     = 4,
  localparam int unsigned SEL_W = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  a_i,
  input  logic                  b_i,
  input  logic                  sel_i,
  output logic [N_CHANNELS-1:0] leds_o,
  output logic [SEL_W-1:0]      ch_sel_o,
  output logic                  step_o
);

  localparam int unsigned DB_CYCLES = CLOCK_FREQ_MHZ * DELAY_IN_US;
  localparam int unsigned DB_W      = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int unsigned W         = PWM_VALUE_SIZE;

  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [W-1:0]    MAX      = '1;
  localparam logic [W-1:0]    CNT_LAST = MAX - 1'b1;
  localparam logic [W:0]      MAX_X    = {1'b0, MAX};
  localparam logic [W-1:0]    INC      = W'(BRIGHTNESS_INC);
  localparam logic [W:0]      INC_X    = (W+1)'(BRIGHTNESS_INC);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CHANNELS - 1);

  // Input bit order: 0 = A, 1 = B, 2 = SEL
  logic [2:0]      raw;
  logic [2:0]      sync1, sync2;
  logic [2:0]      db, db_d;
  logic [DB_W-1:0] db_cnt [3];
  logic [2:0]      fall;

  logic             up_ev, dn_ev, sel_ev;
  logic [SEL_W-1:0] ch_sel;
  logic [W-1:0]     duty     [N_CHANNELS];
  logic [W-1:0]     duty_out [N_CHANNELS];
  logic [W-1:0]     cur_duty;
  logic [W:0]       sum;
  logic [W-1:0]     new_duty;
  logic [W-1:0]     cnt;
  logic             wrap;

  assign raw = {sel_i, b_i, a_i};

  // Two-flop synchronisers, idle high
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: count cycles the synced value differs from the debounced value;
  // any return to the debounced value restarts the count.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      db   <= '1;
      db_d <= '1;
      for (int unsigned k = 0; k < 3; k++) db_cnt[k] <= '0;
    end else begin
      db_d <= db;
      for (int unsigned k = 0; k < 3; k++) begin
        if (sync2[k] == db[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          db[k]     <= sync2[k];
          db_cnt[k] <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + 1'b1;
        end
      end
    end
  end

  // Event decode from debounced falling edges
  always_comb begin
    fall   = db_d & ~db;
    up_ev  = fall[0] & ~fall[1] & db[1];
    dn_ev  = fall[1] & ~fall[0] & db[0];
    sel_ev = fall[2];
  end

  // Saturating next duty for the currently selected channel
  always_comb begin
    cur_duty = '0;
    for (int unsigned k = 0; k < N_CHANNELS; k++) begin
      if (SEL_W'(k) == ch_sel) cur_duty = duty[k];
    end
    sum = {1'b0, cur_duty} + INC_X;
    if (up_ev) begin
      new_duty = (sum > MAX_X) ? MAX : sum[W-1:0];
    end else begin
      new_duty = (cur_duty < INC) ? '0 : cur_duty - INC;
    end
  end

  // Channel select, duty registers and step pulse; a same-cycle select
  // and detent update the duty of the previously selected channel.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ch_sel <= '0;
      step_o <= 1'b0;
      for (int unsigned k = 0; k < N_CHANNELS; k++) duty[k] <= '0;
    end else begin
      step_o <= up_ev | dn_ev;
      if (sel_ev) ch_sel <= (ch_sel == SEL_LAST) ? '0 : ch_sel + 1'b1;
      for (int unsigned k = 0; k < N_CHANNELS; k++) begin
        if ((up_ev || dn_ev) && (SEL_W'(k) == ch_sel)) duty[k] <= new_duty;
      end
    end
  end

  assign ch_sel_o = ch_sel;

  // Shared PWM counter, period MAX cycles
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt <= '0;
    else          cnt <= wrap ? '0 : cnt + 1'b1;
  end

  assign wrap = (cnt == CNT_LAST);

`ifdef LM_FADE_EN
  // Fade: output duty steps one count toward the stored duty per PWM period
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned k = 0; k < N_CHANNELS; k++) duty_out[k] <= '0;
    end else if (wrap) begin
      for (int unsigned k = 0; k < N_CHANNELS; k++) begin
        if (duty_out[k] < duty[k])      duty_out[k] <= duty_out[k] + 1'b1;
        else if (duty_out[k] > duty[k]) duty_out[k] <= duty_out[k] - 1'b1;
      end
    end
  end
`else
  // No fade: compare directly against the stored duty
  always_comb begin
    for (int unsigned k = 0; k < N_CHANNELS; k++) duty_out[k] = duty[k];
  end
`endif

  // Registered PWM compare per channel
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      leds_o <= '0;
    end else begin
      for (int unsigned k = 0; k < N_CHANNELS; k++) leds_o[k] <= (cnt < duty_out[k]);
    end
  end

endmodule
